// File: rtl/bsg_link_pkg.sv
// rtl/bsg_link_pkg.sv - widths and types shared by both directions of the BSG off-chip link
package bsg_link_pkg;

  localparam int CHANNEL_W  = 8;
  localparam int NUM_CH     = 2;
  localparam int CORE_W     = 64;
  localparam int BEAT_W     = NUM_CH * CHANNEL_W;
  localparam int BEATS      = CORE_W / BEAT_W;
  localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORD_CNT_W = 8;

  typedef struct packed {
    logic [CHANNEL_W-1:0] ch1;
    logic [CHANNEL_W-1:0] ch0;
  } beat_t;

  typedef logic [CORE_W-1:0] core_word_t;

  typedef enum logic {
    ST_ASSEMBLE = 1'b0,
    ST_STALL    = 1'b1
  } rx_state_e;

endpackage

// File: rtl/bsg_downstream_deserializer_if.sv
// rtl/bsg_downstream_deserializer_if.sv - link-side beat handshake and core-side word handshake
interface bsg_downstream_deserializer_if;
  import bsg_link_pkg::*;

  logic                  io_valid_in;
  logic [CHANNEL_W-1:0]  io_data_in_ch0;
  logic [CHANNEL_W-1:0]  io_data_in_ch1;
  logic                  io_ready_out;
  core_word_t            core_data_out;
  logic                  core_valid_out;
  logic                  core_yumi_in;
  logic [WORD_CNT_W-1:0] rx_word_cnt;

  modport master (
    output io_valid_in, io_data_in_ch0, io_data_in_ch1, core_yumi_in,
    input  io_ready_out, core_data_out, core_valid_out, rx_word_cnt
  );

  modport slave (
    input  io_valid_in, io_data_in_ch0, io_data_in_ch1, core_yumi_in,
    output io_ready_out, core_data_out, core_valid_out, rx_word_cnt
  );

endinterface

// File: rtl/bsg_link_fifo.sv
// rtl/bsg_link_fifo.sv - small word FIFO using ptr+1-bit wrap detection; head read combinationally
module bsg_link_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is reset so the head never shows X, even while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (i_pop && !o_empty) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/bsg_downstream_deserializer.sv
// rtl/bsg_downstream_deserializer.sv - reassembles 16-bit link beats into 64-bit core words
module bsg_downstream_deserializer
  import bsg_link_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input logic                         clk,
  input logic                         rst,
  bsg_downstream_deserializer_if.slave bus
);

  logic [BEAT_CNT_W-1:0] r_beat_cnt;
  core_word_t            r_asm;
  logic [WORD_CNT_W-1:0] r_word_cnt;

  beat_t      w_beat;
  core_word_t w_word;
  core_word_t w_fifo_data;
  rx_state_e  w_state;
  logic       w_last_beat;
  logic       w_transfer;
  logic       w_push;
  logic       w_pop;
  logic       w_fifo_full;
  logic       w_fifo_empty;

  assign w_beat.ch1 = bus.io_data_in_ch1;
  assign w_beat.ch0 = bus.io_data_in_ch0;

  assign w_last_beat = (r_beat_cnt == BEAT_CNT_W'(BEATS - 1));

  // Stall only when the final beat has nowhere to go; derived purely from registered state.
  assign w_state           = (w_last_beat && w_fifo_full) ? ST_STALL : ST_ASSEMBLE;
  assign bus.io_ready_out  = (w_state == ST_ASSEMBLE);

  assign w_transfer = bus.io_valid_in && bus.io_ready_out;
  assign w_push     = w_transfer && w_last_beat;
  assign w_pop      = bus.core_yumi_in && !w_fifo_empty;

  // The pushed word includes the final beat landing this same edge.
  always_comb begin
    w_word = r_asm;
    for (int k = 0; k < BEATS; k++) begin
      if (r_beat_cnt == BEAT_CNT_W'(k)) begin
        w_word[k*BEAT_W +: BEAT_W] = w_beat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_cnt <= '0;
      r_asm      <= '0;
      r_word_cnt <= '0;
    end else begin
      if (w_transfer) begin
        r_asm      <= w_word;
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
      end
      if (w_push && (r_word_cnt != '1)) begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
    end
  end

  bsg_link_fifo #(
    .WIDTH (CORE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign bus.core_data_out  = w_fifo_data;
  assign bus.core_valid_out = !w_fifo_empty;
  assign bus.rx_word_cnt    = r_word_cnt;

  a_yumi_when_valid: assert property (@(posedge clk) disable iff (!rst)
    bus.core_yumi_in |-> bus.core_valid_out);

endmodule

// File: tb/tb_bsg_downstream_deserializer.sv
// tb/tb_bsg_downstream_deserializer.sv - scoreboard bench for the downstream deserializer
module tb_bsg_downstream_deserializer;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   exp_cnt;
  logic [63:0] sb_q[$];

  bsg_downstream_deserializer_if bus();

  bsg_downstream_deserializer #(.FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] hi, input logic [7:0] lo);
    int n;
    n = 0;
    @(negedge clk);
    bus.io_valid_in    = 1'b1;
    bus.io_data_in_ch1 = hi;
    bus.io_data_in_ch0 = lo;
    while (!bus.io_ready_out && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_eq("beat_accept", 64'(n < 64), 64'd1);
    @(posedge clk);
    #1;
    bus.io_valid_in = 1'b0;
  endtask

  task automatic expect_word(input logic [63:0] w);
    sb_q.push_back(w);
    if (exp_cnt < 255) exp_cnt++;
  endtask

  task automatic send_word(input logic [63:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) expect_word(w);
      send_beat(w[16*k+8 +: 8], w[16*k +: 8]);
      repeat (gap) @(posedge clk);
    end
  endtask

  task automatic pop_word(input string tag);
    int n;
    logic [63:0] exp;
    n = 0;
    @(negedge clk);
    while (!bus.core_valid_out && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 64'(n < 64), 64'd1);
    if (n >= 64) return;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_nonempty"}, 64'd0, 64'd1);
      return;
    end
    exp = sb_q.pop_front();
    check_eq(tag, bus.core_data_out, exp);
    bus.core_yumi_in = 1'b1;
    @(posedge clk);
    #1;
    bus.core_yumi_in = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, 64'(bus.core_valid_out), 64'd0);
    check_eq({tag, "_ready"}, 64'(bus.io_ready_out), 64'd1);
    check_eq({tag, "_cnt"},   64'(bus.rx_word_cnt), 64'd0);
    check_eq({tag, "_data"},  bus.core_data_out, 64'd0);
    check_eq({tag, "_beat"},  64'(dut.r_beat_cnt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] wa, wb, wc, wd, we;
    total = 0;
    bad = 0;
    exp_cnt = 0;
    rst = 1'b0;
    bus.io_valid_in = 1'b0;
    bus.io_data_in_ch0 = '0;
    bus.io_data_in_ch1 = '0;
    bus.core_yumi_in = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b1;

    // basic assembly and latency
    send_beat(8'h22, 8'h11);
    send_beat(8'h44, 8'h33);
    send_beat(8'h66, 8'h55);
    check_eq("t1_not_valid_early", 64'(bus.core_valid_out), 64'd0);
    expect_word(64'h8877665544332211);
    send_beat(8'h88, 8'h77);
    @(negedge clk);
    check_eq("t1_valid", 64'(bus.core_valid_out), 64'd1);
    check_eq("t1_data", bus.core_data_out, 64'h8877665544332211);
    check_eq("t1_cnt", 64'(bus.rx_word_cnt), 64'd1);
    pop_word("t1_pop");

    // backpressure on final beat with FIFO full
    wa = 64'h0102030405060708;
    wb = 64'h1112131415161718;
    wc = 64'hA1B2C3D4E5F60718;
    send_word(wa, 0);
    send_word(wb, 0);
    for (int k = 0; k < 3; k++) send_beat(wc[16*k+8 +: 8], wc[16*k +: 8]);
    check_eq("t2_ready_low", 64'(bus.io_ready_out), 64'd0);
    check_eq("t2_beat_cnt", 64'(dut.r_beat_cnt), 64'd3);
    expect_word(wc);
    pop_word("t2_w1");
    check_eq("t2_ready_back", 64'(bus.io_ready_out), 64'd1);
    send_beat(wc[63:56], wc[55:48]);
    pop_word("t2_w2");
    pop_word("t2_w3");
    check_eq("t2_cnt", 64'(bus.rx_word_cnt), 64'd4);

    // valid toggling every cycle
    send_word(64'hDEADBEEFCAFEF00D, 1);
    send_word(64'h0F1E2D3C4B5A6978, 1);
    pop_word("t3_w1");
    pop_word("t3_w2");
    check_eq("t3_cnt", 64'(bus.rx_word_cnt), 64'd6);

    // final beat coincident with pop, one word buffered
    wd = 64'h1234567890ABCDEF;
    we = 64'hFEDCBA0987654321;
    send_word(wd, 0);
    for (int k = 0; k < 3; k++) send_beat(we[16*k+8 +: 8], we[16*k +: 8]);
    expect_word(we);
    @(negedge clk);
    check_eq("t4_head_d", bus.core_data_out, sb_q.pop_front());
    bus.core_yumi_in   = 1'b1;
    bus.io_valid_in    = 1'b1;
    bus.io_data_in_ch1 = we[63:56];
    bus.io_data_in_ch0 = we[55:48];
    check_eq("t4_ready", 64'(bus.io_ready_out), 64'd1);
    @(posedge clk);
    #1;
    bus.core_yumi_in = 1'b0;
    bus.io_valid_in  = 1'b0;
    @(negedge clk);
    check_eq("t4_valid", 64'(bus.core_valid_out), 64'd1);
    pop_word("t4_head_e");
    @(negedge clk);
    check_eq("t4_empty_after", 64'(bus.core_valid_out), 64'd0);

    // reset mid-word
    send_beat(8'hAB, 8'hCD);
    send_beat(8'h12, 8'h34);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("t5_rst");
    rst = 1'b1;
    sb_q.delete();
    exp_cnt = 0;
    send_word(64'hFFFFFFFFFFFFFFFF, 0);
    @(negedge clk);
    check_eq("t5_data", bus.core_data_out, 64'hFFFFFFFFFFFFFFFF);
    check_eq("t5_cnt", 64'(bus.rx_word_cnt), 64'd1);
    pop_word("t5_pop");

    // streaming with saturation of the word counter
    fork
      begin
        for (int i = 0; i < 300; i++) send_word({$urandom, $urandom}, 0);
      end
      begin
        for (int j = 0; j < 300; j++) pop_word("t6_word");
      end
    join
    @(negedge clk);
    check_eq("t6_cnt_model", 64'(bus.rx_word_cnt), 64'(exp_cnt));
    check_eq("t6_cnt_sat", 64'(bus.rx_word_cnt), 64'd255);
    check_eq("t6_sb_drained", 64'(sb_q.size()), 64'd0);
    check_eq("t6_empty", 64'(bus.core_valid_out), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_downstream_deserializer.md
Name: bsg_downstream_deserializer

Overview:
- Receive end of the BSG off-chip link; counterpart to the upstream block that accepts 64-bit core words and drives them over two 8-bit I/O channels.
- Collects 16-bit beats (ch0 + ch1) from the link, reassembles 64-bit words, and buffers them in a small FIFO.
- Presents words to the core with a valid/yumi handshake and backpressures the link via io_ready_out.

Parameters:
- CHANNEL_W, 8: width of each I/O data channel.
- NUM_CH, 2: number of I/O channels per beat; beat width is NUM_CH*CHANNEL_W (16).
- CORE_W, 64: core word width; must be a multiple of the beat width. BEATS = CORE_W/(NUM_CH*CHANNEL_W) = 4.
- FIFO_DEPTH, 2: number of assembled words buffered; must be a power of two and at least 2.

Ports:
- clk  input  1  the block's single clock.
- rst  input  1  asynchronous, active-low reset. Asserted when 0; takes effect immediately. Deassertion is synchronous to clk, handled upstream.
- io_valid_in  input  1  a beat is present on the channels.
- io_data_in_ch0  input  CHANNEL_W  low byte of the current beat.
- io_data_in_ch1  input  CHANNEL_W  high byte of the current beat.
- io_ready_out  output  1  block accepts a beat this cycle; drives the upstream io_ready.
- core_data_out  output  CORE_W  head word of the FIFO.
- core_valid_out  output  1  FIFO not empty.
- core_yumi_in  input  1  core consumes the head word. Legal only when core_valid_out=1.
- rx_word_cnt  output  8  count of words completed since reset; saturates at 255.

Behaviour:
- Beat transfer: occurs when io_valid_in && io_ready_out on a rising clk edge.
- Assembly packing: beat k (k = 0..BEATS-1) writes shift-register bits [16k+7:16k] from ch0 and [16k+15:16k+8] from ch1. Ordering is little-endian and matches upstream transmit order.
- beat_cnt: width clog2(BEATS).
  - Increments on each transfer.
  - Wraps from BEATS-1 to 0 on the final beat.
  - The final-beat transfer pushes the completed word (including that beat's data) into the FIFO the same edge.
- State machine:
  - ASSEMBLE: beat_cnt < BEATS-1, or FIFO not full.
  - STALL: beat_cnt == BEATS-1 and FIFO full.
- io_ready_out = !(beat_cnt == BEATS-1 && fifo_full).
  - Computed from registered state only; no combinational path from io_valid_in or core_yumi_in.
  - Non-final beats are always accepted, even when the FIFO is full.
- Simultaneous final beat and core_yumi_in while the FIFO is full: io_ready_out is already 0, so the beat is not taken. The pop completes; the beat is accepted next cycle. No bypass path.
- Simultaneous push and pop on a non-full FIFO: both occur, and occupancy is unchanged.
- Read latency: a word is visible on core_data_out and core_valid_out one cycle after its final beat's edge when the FIFO was empty.
- core_data_out: reflects the FIFO head combinationally from the storage array. Undefined when core_valid_out=0, but must not be X after reset; storage is reset to 0.
- core_yumi_in while core_valid_out=0: ignored. No pointer movement; simulation assertion fires.
- rx_word_cnt: increments on each FIFO push and holds at 255.
- Reset values (rst=0): beat_cnt=0, assembly register=0, FIFO pointers=0, FIFO storage=0, core_valid_out=0, io_ready_out=1, rx_word_cnt=0.
- Reset mid-word: the partially assembled word and all buffered words are discarded. The next accepted beat is treated as beat 0.

Decomposition:
- Shared package bsg_link_pkg, used by both directions:
  - CHANNEL_W, NUM_CH, CORE_W, BEATS localparams.
  - beat_t typedef (struct of ch1, ch0 bytes).
  - core_word_t typedef.
- One sub-module: bsg_link_fifo.
  - Parameterised width/depth, ptr+1-bit full/empty scheme.
  - Ports: push/pop/data/full/empty.
  - Reusable by the upstream side.

Test Plan:
- Reset, then 4 beats: (ch1,ch0) = (0x22,0x11), (0x44,0x33), (0x66,0x55), (0x88,0x77) on consecutive cycles. Required: core_data_out=0x8877665544332211, core_valid_out=1 one cycle after beat 4, rx_word_cnt=1.
- Hold core_yumi_in=0 and send 3 words (12 beats). Required: words 1–2 buffered; after beats 9–11, io_ready_out=0 with beat_cnt=3. Assert yumi once: io_ready_out=1 next cycle, the 12th beat is accepted, and core_data_out order is word1, word2, word3.
- io_valid_in toggled 1/0 every cycle across 8 beats. Required: exactly 2 words assembled with correct byte order; no beat lost or duplicated.
- Final beat and core_yumi_in in the same cycle with 1 word buffered. Required: occupancy stays 1 and the new word becomes head next cycle.
- Assert rst=0 after beat 2 of a word, release, then send 4 beats of 0xFF. Required: core_data_out=0xFFFFFFFFFFFFFFFF, no stale bytes, rx_word_cnt=1.
- Stream 300 words with yumi always 1. Required: rx_word_cnt saturates at 255 and data integrity holds for every word.
